tlb_wb_drainer: RTL and testbench

//  Memory-side consumer of the TLB write-back buffer. When the buffer reports a captured dirty line (busy_wb),
//  it steps bank_index across the line and issues one memory write per 2*DATA_WIDTH beat.

---
 rtl/tlb_wb_drainer_if.sv | 33 +++
 rtl/tlb_wb_drainer.sv | 111 +++++++++++
 tb/tb_tlb_wb_drainer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/tlb_wb_drainer_if.sv
// Bundle of buffer-side and memory-side signals of the TLB write-back drainer.
// master = drainer, slave = write buffer / memory environment.
interface tlb_wb_drainer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 4
);
  localparam int BIDX_W = $clog2(BANK_NUM) - 1;

  logic                    busy_wb;
  logic [ADDR_WIDTH-1:0]   addr_mem;
  logic [2*DATA_WIDTH-1:0] data_mem;
  logic [BIDX_W-1:0]       bank_index;
  logic                    finish_wb;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [2*DATA_WIDTH-1:0] mem_wdata;
  logic                    mem_resp_valid;
  logic                    mem_resp_err;
  logic                    drain_active;
  logic                    drain_err;

  modport master (
    input  busy_wb, addr_mem, data_mem, mem_req_ready, mem_resp_valid, mem_resp_err,
    output bank_index, finish_wb, mem_req_valid, mem_addr, mem_wdata, drain_active, drain_err
  );

  modport slave (
    output busy_wb, addr_mem, data_mem, mem_req_ready, mem_resp_valid, mem_resp_err,
    input  bank_index, finish_wb, mem_req_valid, mem_addr, mem_wdata, drain_active, drain_err
  );
endinterface

// File: rtl/tlb_wb_drainer.sv
// Drains one captured dirty line from the TLB write-back buffer, one 2*DATA_WIDTH beat per write.
// Optional feature macro WB_RETRY_EN: re-issue errored beats up to RETRY_MAX times, sticky drain_err.
module tlb_wb_drainer #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 4,
  parameter int RETRY_MAX  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  tlb_wb_drainer_if.master     bus
);
  localparam int NBEAT  = BANK_NUM / 2;
  localparam int BIDX_W = $clog2(BANK_NUM) - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            r_state;
  logic [BIDX_W-1:0]     r_bankIndex;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic                  w_retry;
  logic                  w_advance;
  logic                  w_lastBeat;

  assign w_lastBeat = (r_bankIndex == BIDX_W'(NBEAT - 1));
  assign w_advance  = (r_state == RESP) & bus.mem_resp_valid & ~w_retry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bankIndex <= '0;
      r_memAddr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.busy_wb) begin
            r_state     <= REQ;
            r_bankIndex <= '0;
            r_memAddr   <= bus.addr_mem;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          if (w_retry) begin
            r_state <= REQ;
          end else if (w_advance) begin
            if (w_lastBeat) begin
              r_state <= DONE;
            end else begin
              r_state     <= REQ;
              r_bankIndex <= r_bankIndex + 1'b1;
              r_memAddr   <= r_memAddr + ADDR_WIDTH'(2 * DATA_WIDTH / 8);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_RETRY_EN
  // Counter holds the number of failed re-issues of the current beat; at RETRY_MAX the beat is given up.
  localparam int RCNT_W = ($clog2(RETRY_MAX + 1) < 1) ? 1 : $clog2(RETRY_MAX + 1);

  logic [RCNT_W-1:0] r_retryCnt;
  logic              r_drainErr;
  logic              w_respErr;

  assign w_respErr = (r_state == RESP) & bus.mem_resp_valid & bus.mem_resp_err;
  assign w_retry   = w_respErr & (r_retryCnt != RCNT_W'(RETRY_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retryCnt <= '0;
      r_drainErr <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_retryCnt <= '0;
      end else if (w_retry) begin
        r_retryCnt <= r_retryCnt + 1'b1;
      end else if (w_advance) begin
        r_retryCnt <= '0;
      end
      if (w_respErr && !w_retry) begin
        r_drainErr <= 1'b1;
      end
    end
  end

  assign bus.drain_err = r_drainErr;
`else
  assign w_retry       = 1'b0;
  assign bus.drain_err = 1'b0;
`endif

  assign bus.bank_index    = r_bankIndex;
  assign bus.mem_addr      = r_memAddr;
  assign bus.mem_wdata     = bus.data_mem;
  assign bus.mem_req_valid = (r_state == REQ);
  assign bus.finish_wb     = (r_state == DONE);
  assign bus.drain_active  = (r_state != IDLE);
endmodule

// File: tb/tb_tlb_wb_drainer.sv
// Directed self-checking bench for tlb_wb_drainer (BANK_NUM=4, two beats per line).
// Buffer data is modelled as {line base, 0xA5A5 marker, beat index}.
module tb_tlb_wb_drainer;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BN = 4;
  localparam int RM = 3;

  logic clk;
  logic rst;

  tlb_wb_drainer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) bus ();

  tlb_wb_drainer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN), .RETRY_MAX(RM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.data_mem = {bus.addr_mem, 64'hA5A5_0000_0000_0000 | 64'(bus.bank_index)};

  int              vectorCount = 0;
  int              missCount   = 0;
  int              finishCount = 0;
  int              stallCycles = 0;
  bit              errOnBeat0  = 0;
  bit              acceptedPrev = 0;
  logic [AW-1:0]   reqAddrQ[$];
  logic [2*DW-1:0] reqDataQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: accepts in REQ (after optional stall), answers exactly one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_err   = 1'b0;
      acceptedPrev       = 0;
    end else begin
      bus.mem_resp_valid = acceptedPrev;
      bus.mem_resp_err   = acceptedPrev && errOnBeat0 && (bus.bank_index == '0);
      acceptedPrev       = 0;
      if (bus.mem_req_valid) begin
        if (stallCycles > 0) begin
          bus.mem_req_ready = 1'b0;
          stallCycles--;
        end else begin
          bus.mem_req_ready = 1'b1;
          reqAddrQ.push_back(bus.mem_addr);
          reqDataQ.push_back(bus.mem_wdata);
          acceptedPrev = 1;
        end
      end else begin
        bus.mem_req_ready = 1'b0;
      end
      if (bus.finish_wb) finishCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr);
    @(negedge clk);
    bus.addr_mem = addr;
    bus.busy_wb  = 1'b1;
  endtask

  task automatic waitFinish(input int maxCycles, output int cycles);
    cycles = 0;
    while (cycles < maxCycles) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.finish_wb) break;
    end
    checkOutput("finishSeen", 128'(bus.finish_wb), 128'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cycles;
    rst                = 1'b1;
    bus.busy_wb        = 1'b0;
    bus.addr_mem       = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstBank",   128'(bus.bank_index),    128'd0);
    checkOutput("rstFinish", 128'(bus.finish_wb),     128'd0);
    checkOutput("rstValid",  128'(bus.mem_req_valid), 128'd0);
    checkOutput("rstAddr",   128'(bus.mem_addr),      128'd0);
    checkOutput("rstErr",    128'(bus.drain_err),     128'd0);
    checkOutput("rstActive", 128'(bus.drain_active),  128'd0);

    // Basic two-beat line, zero-wait memory
    $display("[TB] basic line at 0x1000");
    reqAddrQ.delete(); reqDataQ.delete(); finishCount = 0;
    applyStimulus(64'h1000);
    waitFinish(20, cycles);
    bus.busy_wb = 1'b0;
    checkOutput("basicLatency", 128'(cycles), 128'd5);
    @(posedge clk); #1;
    checkOutput("basicPulseLen", 128'(bus.finish_wb),    128'd0);
    checkOutput("basicIdle",     128'(bus.drain_active), 128'd0);
    checkOutput("basicFinishes", 128'(finishCount),      128'd1);
    checkOutput("basicReqs",     128'(reqAddrQ.size()),  128'd2);
    checkOutput("basicAddr0",    128'(reqAddrQ[0]),      128'h1000);
    checkOutput("basicAddr1",    128'(reqAddrQ[1]),      128'h1010);
    checkOutput("basicData0",    reqDataQ[0], {64'h1000, 64'hA5A5_0000_0000_0000});
    checkOutput("basicData1",    reqDataQ[1], {64'h1000, 64'hA5A5_0000_0000_0001});

    // Memory stalls beat 0 for three cycles
    $display("[TB] stalled accept on beat 0");
    reqAddrQ.delete(); reqDataQ.delete(); finishCount = 0;
    stallCycles = 3;
    applyStimulus(64'h1000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stallValid", 128'(bus.mem_req_valid), 128'd1);
      checkOutput("stallAddr",  128'(bus.mem_addr),      128'h1000);
      checkOutput("stallData",  bus.mem_wdata, {64'h1000, 64'hA5A5_0000_0000_0000});
    end
    waitFinish(20, cycles);
    bus.busy_wb = 1'b0;
    checkOutput("stallLatency", 128'(cycles + 3),      128'd8);
    @(posedge clk); #1;
    checkOutput("stallReqs",    128'(reqAddrQ.size()), 128'd2);
    checkOutput("stallAddr1",   128'(reqAddrQ[1]),     128'h1010);

    // Back-to-back line captured in the finish cycle
    $display("[TB] back-to-back lines");
    reqAddrQ.delete(); reqDataQ.delete(); finishCount = 0;
    applyStimulus(64'h1000);
    waitFinish(20, cycles);
    bus.addr_mem = 64'h2000;
    @(posedge clk); #1;
    checkOutput("b2bIdleGap", 128'(bus.drain_active), 128'd0);
    waitFinish(20, cycles);
    bus.busy_wb = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2bFinishes", 128'(finishCount),     128'd2);
    checkOutput("b2bReqs",     128'(reqAddrQ.size()), 128'd4);
    checkOutput("b2bAddr2",    128'(reqAddrQ[2]),     128'h2000);
    checkOutput("b2bAddr3",    128'(reqAddrQ[3]),     128'h2010);
    checkOutput("b2bData2",    reqDataQ[2], {64'h2000, 64'hA5A5_0000_0000_0000});

    // Reset during RESP of beat 1, then redrain from beat 0
    $display("[TB] reset mid-line");
    applyStimulus(64'h1000);
    cycles = 0;
    while (cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.bank_index == 1'b1 && bus.drain_active && !bus.mem_req_valid) break;
    end
    checkOutput("midReachResp1", 128'(bus.bank_index == 1'b1 && bus.drain_active && !bus.mem_req_valid), 128'd1);
    rst = 1'b1;
    #1;
    checkOutput("midRstActive", 128'(bus.drain_active),  128'd0);
    checkOutput("midRstValid",  128'(bus.mem_req_valid), 128'd0);
    checkOutput("midRstBank",   128'(bus.bank_index),    128'd0);
    checkOutput("midRstAddr",   128'(bus.mem_addr),      128'd0);
    checkOutput("midRstFinish", 128'(bus.finish_wb),     128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reqAddrQ.delete(); reqDataQ.delete();
    waitFinish(20, cycles);
    bus.busy_wb = 1'b0;
    @(posedge clk); #1;
    checkOutput("redrainReqs",  128'(reqAddrQ.size()), 128'd2);
    checkOutput("redrainAddr0", 128'(reqAddrQ[0]),     128'h1000);
    checkOutput("redrainData0", reqDataQ[0], {64'h1000, 64'hA5A5_0000_0000_0000});

    // Error response on every beat-0 attempt
    $display("[TB] error responses on beat 0");
    reqAddrQ.delete(); reqDataQ.delete();
    errOnBeat0 = 1;
    applyStimulus(64'h1000);
    waitFinish(40, cycles);
    bus.busy_wb = 1'b0;
    errOnBeat0  = 0;
    @(posedge clk); #1;
`ifdef WB_RETRY_EN
    checkOutput("errReqs",  128'(reqAddrQ.size()), 128'd5);
    checkOutput("errAddr0", 128'(reqAddrQ[0]),     128'h1000);
    checkOutput("errAddr3", 128'(reqAddrQ[3]),     128'h1000);
    checkOutput("errAddr4", 128'(reqAddrQ[4]),     128'h1010);
    checkOutput("errFlag",  128'(bus.drain_err),   128'd1);
`else
    checkOutput("errReqs",  128'(reqAddrQ.size()), 128'd2);
    checkOutput("errAddr0", 128'(reqAddrQ[0]),     128'h1000);
    checkOutput("errAddr1", 128'(reqAddrQ[1]),     128'h1010);
    checkOutput("errFlag",  128'(bus.drain_err),   128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
